// File: rtl/wb_data_interconnect.sv
// wb_data_interconnect
//   Single-master, N-slave pipelined Wishbone interconnect for the core data
//   port. Each request is decoded against inclusive per-slave address ranges
//   (lowest slave index wins on overlap). At most one transaction is
//   outstanding. Unmapped addresses and slaves that do not answer within
//   TIMEOUT cycles are answered with a bus error.
//
// Ports
//   clk_i, reset_i        clock (rising edge), asynchronous active-low reset
//   m_wb_*                master side (core data port)
//   s_wb_cyc/stb/we_o     per-slave cycle/strobe/write (NUM_SLAVES bits)
//   s_wb_adr/dat/sel_o    broadcast to all slaves
//   s_wb_stall/ack/err_i  per-slave handshake inputs
//   s_wb_dat_i            flattened slave read data, slave i at [i*DAT_W +: DAT_W]
//   busy_o                transaction in flight (WAIT or ERR)
//   timeout_o             one-cycle pulse when a timeout error is issued
//
// States
//   IDLE | no transaction in flight; request routed combinationally
//   WAIT | request accepted by slave idx_q, waiting for ack/err/timeout
//   ERR  | unmapped request accepted, issue one-cycle master error
module wb_data_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADR_W      = 32,
  parameter int DAT_W      = 32,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_END  = '0,
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = DAT_W / 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        m_wb_cyc_i,
  input  logic                        m_wb_stb_i,
  input  logic                        m_wb_we_i,
  input  logic [ADR_W-1:0]            m_wb_adr_i,
  input  logic [DAT_W-1:0]            m_wb_dat_i,
  input  logic [SEL_W-1:0]            m_wb_sel_i,
  output logic                        m_wb_stall_o,
  output logic                        m_wb_ack_o,
  output logic                        m_wb_err_o,
  output logic [DAT_W-1:0]            m_wb_dat_o,
  output logic [NUM_SLAVES-1:0]       s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_wb_stb_o,
  output logic [NUM_SLAVES-1:0]       s_wb_we_o,
  output logic [ADR_W-1:0]            s_wb_adr_o,
  output logic [DAT_W-1:0]            s_wb_dat_o,
  output logic [SEL_W-1:0]            s_wb_sel_o,
  input  logic [NUM_SLAVES-1:0]       s_wb_stall_i,
  input  logic [NUM_SLAVES-1:0]       s_wb_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_wb_err_i,
  input  logic [NUM_SLAVES*DAT_W-1:0] s_wb_dat_i,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   hit;
  logic                    miss;
  logic [IDX_W-1:0]        sel_idx;
  logic                    req_stall;

  // Address decode; scanning downward leaves the lowest hitting index.
  always_comb begin
    hit     = '0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      hit[i] = (m_wb_adr_i >= SLAVE_BASE[i*ADR_W +: ADR_W]) &&
               (m_wb_adr_i <= SLAVE_END[i*ADR_W +: ADR_W]);
      if (hit[i]) sel_idx = IDX_W'(i);
    end
    miss = ~|hit;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    req_stall    = 1'b1;
    m_wb_ack_o   = 1'b0;
    m_wb_err_o   = 1'b0;
    m_wb_dat_o   = '0;
    s_wb_cyc_o   = '0;
    s_wb_stb_o   = '0;
    timeout_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_stall = m_wb_cyc_i & m_wb_stb_i & ~miss & s_wb_stall_i[sel_idx];
        if (!miss) begin
          s_wb_cyc_o[sel_idx] = m_wb_cyc_i;
          s_wb_stb_o[sel_idx] = m_wb_cyc_i & m_wb_stb_i;
        end
        if (m_wb_cyc_i && m_wb_stb_i && !req_stall) begin
          if (miss) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_WAIT;
            idx_d   = sel_idx;
            cnt_d   = '0;
          end
        end
      end

      ST_WAIT: begin
        s_wb_cyc_o[idx_q] = m_wb_cyc_i;
        if (!m_wb_cyc_i) begin
          // Master abandoned the cycle: leave silently.
          state_d = ST_IDLE;
        end else if (s_wb_err_i[idx_q]) begin
          m_wb_err_o = 1'b1;
          state_d    = ST_IDLE;
        end else if (s_wb_ack_i[idx_q]) begin
          m_wb_ack_o = 1'b1;
          m_wb_dat_o = s_wb_dat_i[idx_q*DAT_W +: DAT_W];
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          m_wb_err_o = 1'b1;
          timeout_o  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ERR: begin
        m_wb_err_o = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // While reset is held the slaves must see no cycle and the master a stall.
    if (!reset_i) begin
      req_stall  = 1'b1;
      s_wb_cyc_o = '0;
      s_wb_stb_o = '0;
    end
  end

  assign m_wb_stall_o = req_stall;
  assign busy_o       = (state_q != ST_IDLE);

  assign s_wb_adr_o = m_wb_adr_i;
  assign s_wb_dat_o = m_wb_dat_i;
  assign s_wb_sel_o = m_wb_sel_i;
  assign s_wb_we_o  = {NUM_SLAVES{m_wb_we_i}};

endmodule

// File: tb/tb_wb_data_interconnect.sv
module tb_wb_data_interconnect;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // slave0 0x0000-0x1DFF, slave1 0x2000-0x200F, slave2 0x2010, slave3 0x0000-0x1FFF
  localparam logic [NS*AW-1:0] BASES = {32'h0000_0000, 32'h0000_2010, 32'h0000_2000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] ENDS  = {32'h0000_1FFF, 32'h0000_2010, 32'h0000_200F, 32'h0000_1DFF};

  logic clk = 1'b0;
  logic rst_n;
  logic m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdat;
  logic [SW-1:0] m_sel;
  logic m_stall, m_ack, m_err;
  logic [DW-1:0] m_rdat;
  logic [NS-1:0] s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [SW-1:0] s_sel;
  logic [NS-1:0] s_stall, s_ack, s_err;
  logic [NS*DW-1:0] s_rdat;
  logic busy, tmo;

  int n_cmp = 0;
  int n_err = 0;

  // Reference address map, in slave order (first match wins).
  int unsigned map_base [NS] = '{32'h0000, 32'h2000, 32'h2010, 32'h0000};
  int unsigned map_end  [NS] = '{32'h1DFF, 32'h200F, 32'h2010, 32'h1FFF};

  always #5 clk = ~clk;

  wb_data_interconnect #(
    .NUM_SLAVES(NS), .ADR_W(AW), .DAT_W(DW),
    .SLAVE_BASE(BASES), .SLAVE_END(ENDS), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_i(rst_n),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_wdat), .m_wb_sel_i(m_sel),
    .m_wb_stall_o(m_stall), .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .m_wb_dat_o(m_rdat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .s_wb_dat_i(s_rdat),
    .busy_o(busy), .timeout_o(tmo)
  );

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= map_base[i] && a <= map_end[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_slave_dat();
    for (int i = 0; i < NS; i++) s_rdat[i*DW +: DW] = $urandom;
  endtask

  // resp: 0 = ack, 1 = err, 2 = never respond. delay: WAIT cycle of the response.
  task automatic do_txn(input logic [31:0] adr, input logic we, input int resp,
                        input int delay, input int stalls, input logic [31:0] rdata,
                        input logic noise);
    int tgt;
    int nst;
    int last;
    logic [NS-1:0] oh;
    logic [DW-1:0] wd;
    logic [SW-1:0] sl;
    logic exp_ack, exp_err, exp_to;
    tgt = decode(adr);
    oh  = (tgt >= 0) ? NS'(1 << tgt) : '0;
    nst = (tgt >= 0) ? stalls : 0;
    wd  = $urandom;
    sl  = SW'($urandom);
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_wdat = wd; m_sel = sl;
    for (int k = 0; k < nst; k++) begin
      s_stall = noise ? (NS'($urandom) | oh) : oh;
      @(negedge clk);
      chk("stall_hold", 32'(m_stall), 32'd1);
      chk("stb_hold", 32'(s_stb), 32'(oh));
      chk("busy_hold", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    s_stall = noise ? (NS'($urandom) & ~oh) : '0;
    @(negedge clk);
    chk("acc_stall", 32'(m_stall), 32'd0);
    chk("acc_stb", 32'(s_stb), 32'(oh));
    chk("acc_cyc", 32'(s_cyc), 32'(oh));
    chk("acc_adr", s_adr, adr);
    chk("acc_wdat", s_wdat, wd);
    chk("acc_sel", 32'(s_sel), 32'(sl));
    chk("acc_we", 32'(s_we), 32'({NS{we}}));
    chk("acc_ack", 32'(m_ack), 32'd0);
    @(posedge clk); #1;
    m_stb = 1'b0; s_stall = '0;
    if (tgt < 0) begin
      @(negedge clk);
      chk("miss_err", 32'(m_err), 32'd1);
      chk("miss_ack", 32'(m_ack), 32'd0);
      chk("miss_stall", 32'(m_stall), 32'd1);
      chk("miss_busy", 32'(busy), 32'd1);
      chk("miss_stb", 32'(s_stb | s_cyc), 32'd0);
      chk("miss_to", 32'(tmo), 32'd0);
      @(posedge clk); #1;
      m_cyc = 1'b0;
      @(negedge clk);
      chk("miss_err_end", 32'(m_err), 32'd0);
      chk("miss_busy_end", 32'(busy), 32'd0);
    end else begin
      last = (resp == 2) ? TO : delay;
      for (int c = 1; c <= last; c++) begin
        s_ack = noise ? (NS'($urandom) & ~oh) : '0;
        s_err = noise ? (NS'($urandom) & ~oh) : '0;
        rand_slave_dat();
        if (c == last && resp == 0) begin
          s_ack = s_ack | oh;
          s_rdat[tgt*DW +: DW] = rdata;
        end
        if (c == last && resp == 1) s_err = s_err | oh;
        exp_ack = (c == last) && (resp == 0);
        exp_err = (c == last) && (resp != 0);
        exp_to  = (c == last) && (resp == 2);
        @(negedge clk);
        chk("w_ack", 32'(m_ack), 32'(exp_ack));
        chk("w_err", 32'(m_err), 32'(exp_err));
        chk("w_timeout", 32'(tmo), 32'(exp_to));
        chk("w_rdat", m_rdat, exp_ack ? rdata : 32'h0);
        chk("w_stall", 32'(m_stall), 32'd1);
        chk("w_busy", 32'(busy), 32'd1);
        chk("w_stb", 32'(s_stb), 32'd0);
        chk("w_cyc", 32'(s_cyc), 32'(oh));
        @(posedge clk); #1;
      end
      s_ack = '0; s_err = '0;
      if (resp == 2) begin
        s_ack = oh;
        s_rdat[tgt*DW +: DW] = 32'hBAD0_0ACC;
        @(negedge clk);
        chk("late_ack", 32'(m_ack), 32'd0);
        chk("late_rdat", m_rdat, 32'h0);
        chk("late_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        s_ack = '0;
      end
      m_cyc = 1'b0;
      @(negedge clk);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_ack", 32'(m_ack), 32'd0);
      chk("end_err", 32'(m_err), 32'd0);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cyc"}, 32'(s_cyc), 32'd0);
    chk({tag, "_stb"}, 32'(s_stb), 32'd0);
    chk({tag, "_stall"}, 32'(m_stall), 32'd1);
    chk({tag, "_ack"}, 32'(m_ack), 32'd0);
    chk({tag, "_err"}, 32'(m_err), 32'd0);
    chk({tag, "_to"}, 32'(tmo), 32'd0);
    chk({tag, "_rdat"}, m_rdat, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sel, r, rs;
    logic [31:0] a;
    rst_n = 1'b0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h2004; m_wdat = '0; m_sel = '0;
    s_stall = '0; s_ack = 4'b0010; s_err = '0; s_rdat = '0;
    #3;
    chk_reset_values("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;

    // Read 0x2004 from slave1, ack next cycle.
    do_txn(32'h2004, 1'b0, 0, 1, 0, 32'hDEAD_BEEF, 1'b0);
    // Overlap: lowest index wins below 0x1E00, slave3 above.
    do_txn(32'h0100, 1'b1, 0, 1, 0, 32'h1111_0100, 1'b0);
    do_txn(32'h1E00, 1'b1, 0, 2, 0, 32'h3333_1E00, 1'b0);
    // Unmapped.
    do_txn(32'h3000, 1'b0, 0, 1, 0, 32'h0, 1'b0);
    // Timeout on the single-address slave, then a late ack.
    do_txn(32'h2010, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    // Slave stalls three cycles, then errors.
    do_txn(32'h0040, 1'b0, 1, 1, 3, 32'h0, 1'b0);

    // Reset pulled during WAIT.
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h2008; m_we = 1'b0;
    @(posedge clk); #1;
    m_stb = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    s_ack = 4'b0010; s_rdat[1*DW +: DW] = 32'hCAFE_F00D;
    #1;
    chk_reset_values("rstw");
    @(posedge clk); #1;
    chk_reset_values("rstw2");
    rst_n = 1'b1; m_cyc = 1'b0; s_ack = '0;
    do_txn(32'h2008, 1'b0, 0, 1, 0, 32'h5A5A_A5A5, 1'b0);

    // Randomized traffic with noise on the other slaves.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 32'($urandom_range(32'h0000, 32'h1DFF));
        1: a = 32'($urandom_range(32'h2000, 32'h200F));
        2: a = 32'h2010;
        3: a = 32'($urandom_range(32'h1E00, 32'h1FFF));
        4: begin
          r = $urandom_range(0, 5);
          case (r)
            0: a = 32'h1DFF;
            1: a = 32'h1E00;
            2: a = 32'h1FFF;
            3: a = 32'h200F;
            4: a = 32'h2011;
            default: a = 32'hFFFF_FFFF;
          endcase
        end
        default: a = 32'($urandom_range(32'h2011, 32'hFFFF));
      endcase
      rs = $urandom_range(0, 9);
      r  = (rs < 7) ? 0 : (rs < 9) ? 1 : 2;
      do_txn(a, 1'($urandom), r, $urandom_range(1, 4), $urandom_range(0, 2), $urandom, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_data_interconnect.md
# wb_data_interconnect

Parametrised single-master, N-slave Wishbone (pipelined) interconnect for the core's data port, replacing fixed hand-written decode in SoC top levels. Decodes each request against per-slave inclusive address ranges (lowest index wins on overlap) and tracks one outstanding transaction. Routes the response back to the master, and generates a bus error for unmapped addresses or slaves that fail to respond within a timeout. Sits between `core_wb` data port and peripherals (data memory port, mtime registers, debug interface, future devices).

## Interface
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADR_W, 32, address width
- DAT_W, 32, data width; SEL_W = DAT_W/8
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, flattened ADR_W-bit inclusive base per slave, slave i at bits [i*ADR_W +: ADR_W]
- SLAVE_END, {NUM_SLAVES{32'h0}}, flattened inclusive end address per slave, same packing
- TIMEOUT, 255, cycles in WAIT without ack/err before bus error (≥1); counter width $clog2(TIMEOUT+1)
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- m_wb_cyc_i, m_wb_stb_i, m_wb_we_i  in  1 each  master cycle/strobe/write
- m_wb_adr_i  in  ADR_W;  m_wb_dat_i  in  DAT_W;  m_wb_sel_i  in  SEL_W
- m_wb_stall_o, m_wb_ack_o, m_wb_err_o  out  1 each
- m_wb_dat_o  out  DAT_W  read data of responding slave, 0 otherwise
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  NUM_SLAVES  per-slave
- s_wb_adr_o  out  ADR_W;  s_wb_dat_o  out  DAT_W;  s_wb_sel_o  out  SEL_W  broadcast to all slaves
- s_wb_stall_i, s_wb_ack_i, s_wb_err_i  in  NUM_SLAVES
- s_wb_dat_i  in  NUM_SLAVES*DAT_W  flattened slave read data
- busy_o  out  1  high in WAIT or ERR
- timeout_o  out  1  one-cycle pulse when a timeout error is issued

## Operation
- Decode (combinational): hit[i] = BASE[i] <= adr <= END[i]; sel_idx = lowest set hit index; miss = no hit.
- States IDLE, WAIT, ERR; idx register (slave index), cnt register.
- IDLE: m_wb_stall_o = m_cyc & m_stb & ~miss & s_wb_stall_i[sel_idx]. s_wb_stb_o[sel_idx] = m_stb & m_cyc; s_wb_cyc_o[sel_idx] = m_cyc; other bits 0. m_ack/m_err/m_dat = 0; slave ack/err ignored.
- IDLE, request accepted (cyc & stb & ~stall): hit -> WAIT, idx<=sel_idx, cnt<=0; miss -> ERR, no slave strobed.
- WAIT: m_wb_stall_o = 1; all s_wb_stb_o = 0; s_wb_cyc_o[idx] = m_cyc. m_ack = s_ack[idx], m_err = s_err[idx], m_dat = s_ack[idx] ? s_dat[idx] : 0. Ack or err -> IDLE (err has priority if both). cnt increments; cnt == TIMEOUT-1 with no ack/err -> m_err=1 this cycle, timeout_o=1, -> IDLE. Master drops cyc -> IDLE, no response issued.
- ERR: m_wb_err_o = 1 for exactly one cycle, m_wb_stall_o = 1, -> IDLE.
- Late slave ack after timeout/abort arrives in IDLE and is dropped.
- adr/dat/sel/we broadcast unconditionally.

## Timing
- Reset (reset_i low): state IDLE, idx 0, cnt 0; all s_wb_cyc_o/s_wb_stb_o forced 0, m_wb_stall_o 1, m_ack/m_err/timeout_o 0, m_dat 0, busy_o 0. Release takes effect on the next rising edge.
- Request path zero latency (combinational); response path zero added latency.
- Minimum transaction: accept cycle N, slave ack at N+1, master sees ack at N+1; next request accepted at N+2 earliest... in IDLE at N+2.
- Unmapped access: accepted at N, m_err at N+1.
- Timeout: accepted at N, m_err and timeout_o at N+TIMEOUT.
- Reset asserted mid-WAIT: immediate return to IDLE, no response to master.

## Test plan
- Map slave0 0x0000–0x1FFF, slave1 0x2000–0x200F, slave2 0x2010–0x2010; read 0x2004, slave1 acks next cycle with 0xDEADBEEF -> only s_stb[1] pulsed one cycle, m_ack=1 with m_dat=0xDEADBEEF, m_stall high during WAIT.
- Overlap slave0 0x0000–0x1DFF, slave1 0x0000–0x1FFF; write 0x0100 -> slave0 strobed; write 0x1E00 -> slave1 strobed.
- Access 0x3000 (unmapped) -> no s_stb, m_err=1 exactly one cycle after accept, busy_o one cycle.
- TIMEOUT=8, slave never acks -> m_err and timeout_o at accept+8; later slave ack ignored (m_ack stays 0).
- Slave holds stall 3 cycles -> m_stall high 3 cycles, s_stb held, WAIT entered only when stall drops; then slave err -> m_err=1, back to IDLE.
- Pull reset_i low during WAIT, release, issue new read -> all outputs at reset values while low, new transaction completes normally.
